// File: rtl/storage_pkg.sv
// Shared constants and tag type for the storage port arbiter.
// Default build is round-robin; defining ARB_FIXED_PRIO_EN selects fixed lowest-index priority.
package storage_pkg;

    localparam int unsigned ADDR_W_DEF      = 9;
    localparam int unsigned DATA_W_DEF      = 32;
    localparam int unsigned NUM_CLIENTS_DEF = 3;

    localparam int unsigned CLI_INPUT   = 0;
    localparam int unsigned CLI_DISPLAY = 1;
    localparam int unsigned CLI_CALC    = 2;

    // Tag index is sized for up to 16 clients regardless of the instance count.
    localparam int unsigned TAG_IDX_W = 4;

    typedef struct packed {
        logic                 valid;
        logic [TAG_IDX_W-1:0] idx;
    } tag_t;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Rotate-and-find-first: first set request at or above the pointer, wrapping around.
module rr_picker #(
    parameter int unsigned N     = 3,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_gnt,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    int unsigned j;

    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        j     = 0;
        for (int unsigned i = 0; i < N; i++) begin
            j = 32'(i_ptr) + i;
            if (j >= N) j = j - N;
            if (!o_any && i_req[IDX_W'(j)]) begin
                o_any              = 1'b1;
                o_gnt[IDX_W'(j)]   = 1'b1;
                o_idx              = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/storage_port_arbiter.sv
// Arbitrates client request ports onto one synchronous-read storage port with burst lock
// and tagged read return. ARB_FIXED_PRIO_EN replaces round-robin with lowest-index priority.
module storage_port_arbiter
    import storage_pkg::*;
#(
    parameter int unsigned NUM_CLIENTS = NUM_CLIENTS_DEF,
    parameter int unsigned ADDR_W      = ADDR_W_DEF,
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned RD_LAT      = 1,
    localparam int unsigned IDX_W      = idx_w(NUM_CLIENTS)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_CLIENTS-1:0]        i_client_en,
    input  logic [NUM_CLIENTS-1:0]        i_req,
    input  logic [NUM_CLIENTS-1:0]        i_we,
    input  logic [NUM_CLIENTS-1:0]        i_lock,
    input  logic [NUM_CLIENTS*ADDR_W-1:0] i_addr,
    input  logic [NUM_CLIENTS*DATA_W-1:0] i_wdata,
    output logic [NUM_CLIENTS-1:0]        o_gnt,
    output logic [NUM_CLIENTS-1:0]        o_rvalid,
    output logic [DATA_W-1:0]             o_rdata,
    output logic [IDX_W-1:0]              o_owner,
    output logic                          o_busy,
    output logic                          mem_we,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
    input  logic [DATA_W-1:0]             mem_rdata
);

    localparam int unsigned DEPTH = RD_LAT + 1;

    logic [NUM_CLIENTS-1:0] elig_c, pick_gnt, gnt_c;
    logic [IDX_W-1:0]       pick_idx, win_idx, ptr;
    logic                   pick_any, lock_win, win_any;

    logic [IDX_W-1:0]  owner_q, owner_d;
    logic              lock_q, lock_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    tag_t              tag_q [DEPTH];
    tag_t              tag_d [DEPTH];

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] k);
        return (32'(k) == NUM_CLIENTS - 1) ? '0 : k + IDX_W'(1);
    endfunction

    assign elig_c = i_req & i_client_en;

`ifdef ARB_FIXED_PRIO_EN
    assign ptr = '0;
`else
    logic [IDX_W-1:0] rr_q, rr_d;

    // Fairness pointer: advances on unlocked grants and on lock release.
    always_comb begin
        rr_d = rr_q;
        if (lock_q && !lock_win) rr_d = next_idx(owner_q);
        if (win_any && !i_lock[win_idx]) rr_d = next_idx(win_idx);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rr_q <= '0;
        else        rr_q <= rr_d;
    end

    assign ptr = rr_q;
`endif

    rr_picker #(
        .N     (NUM_CLIENTS),
        .IDX_W (IDX_W)
    ) u_picker (
        .i_req (elig_c),
        .i_ptr (ptr),
        .o_gnt (pick_gnt),
        .o_idx (pick_idx),
        .o_any (pick_any)
    );

    // A held lock overrides the picker while the owner keeps requesting with lock.
    always_comb begin
        lock_win = lock_q && elig_c[owner_q] && i_lock[owner_q];
        gnt_c    = pick_gnt;
        win_idx  = pick_idx;
        win_any  = pick_any;
        if (lock_win) begin
            gnt_c   = NUM_CLIENTS'(1) << owner_q;
            win_idx = owner_q;
            win_any = 1'b1;
        end
    end

    always_comb begin
        owner_d     = owner_q;
        lock_d      = lock_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        tag_d[0]    = '0;
        for (int unsigned i = 1; i < DEPTH; i++) tag_d[i] = tag_q[i-1];
        if (lock_q && !lock_win) lock_d = 1'b0;
        if (win_any) begin
            owner_d         = win_idx;
            lock_d          = i_lock[win_idx];
            mem_we_d        = i_we[win_idx];
            mem_addr_d      = i_addr[32'(win_idx)*ADDR_W +: ADDR_W];
            mem_wdata_d     = i_wdata[32'(win_idx)*DATA_W +: DATA_W];
            tag_d[0].valid  = !i_we[win_idx];
            tag_d[0].idx    = TAG_IDX_W'(win_idx);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q     <= '0;
            lock_q      <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) tag_q[i] <= '0;
        end else begin
            owner_q     <= owner_d;
            lock_q      <= lock_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            for (int unsigned i = 0; i < DEPTH; i++) tag_q[i] <= tag_d[i];
        end
    end

    // Tag at the end of the pipeline lines up with mem_rdata for that read.
    always_comb begin
        o_rvalid = '0;
        o_busy   = 1'b0;
        for (int unsigned i = 0; i < NUM_CLIENTS; i++)
            o_rvalid[i] = tag_q[RD_LAT].valid && (32'(tag_q[RD_LAT].idx) == i);
        for (int unsigned i = 0; i < DEPTH; i++)
            o_busy = o_busy | tag_q[i].valid;
    end

    assign o_gnt     = gnt_c;
    assign o_rdata   = mem_rdata;
    assign o_owner   = owner_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule
